// File: rtl/booth_div_32_bit.sv
// Signed restoring divider, one quotient bit per clock.
// Ports: clk, clr_n, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero, overflow.
module booth_div_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;
  logic             zero_f;
  logic             ovf_f;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             a_min;
  logic             b_zero;
  logic             b_ones;

  // |most-negative| = 2^(WIDTH-1) still fits as unsigned
  always_comb begin
    a_abs  = dividend[WIDTH-1] ? -dividend : dividend;
    b_abs  = divisor[WIDTH-1] ? -divisor : divisor;
    a_min  = (dividend == {1'b1, {(WIDTH-1){1'b0}}});
    b_zero = ~|divisor;
    b_ones = &divisor;
  end

  // Stored remainder is always below |divisor| (or the
  // partial dividend when dividing by zero), so WIDTH
  // bits hold it; the working value is WIDTH+1 bits.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = CALC;
      CALC: if (cnt == LAST) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvsr        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_f      <= 1'b0;
      ovf_f       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q      <= a_abs;
            dvsr   <= b_abs;
            rem    <= '0;
            // zero divisor leaves q all ones; keep it positive
            sign_q <= ~b_zero &
                      (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r <= dividend[WIDTH-1];
            zero_f <= b_zero;
            ovf_f  <= a_min & b_ones;
            cnt    <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient    <= sign_q ? -q : q;
          remainder   <= sign_r ? -rem : rem;
          div_by_zero <= zero_f;
          overflow    <= ovf_f;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_div_32_bit.md
Name: booth_div_32_bit

Overview:
- Sequential signed integer divider: the inverse of the datapath's 32-bit Booth multiplier.
- Divides a WIDTH-bit dividend by a WIDTH-bit divisor in two's complement.
- Produces the quotient (LO) and remainder (HI) for the CPU's DIV instruction.
- Uses a radix-2 restoring algorithm, one quotient bit per clock, with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active
- clr_n  input  1  asynchronous active-low reset
- start  input  1  request a divide; sampled only in IDLE
- dividend  input  WIDTH  signed dividend; sampled on the accepting edge only
- divisor  input  WIDTH  signed divisor; sampled on the accepting edge only
- busy  output  1  high while a divide is in progress
- done  output  1  one-cycle pulse; quotient/remainder valid
- quotient  output  WIDTH  signed quotient (LO)
- remainder  output  WIDTH  signed remainder (HI)
- div_by_zero  output  1  divisor was zero for the last completed divide
- overflow  output  1  last divide was most-negative / -1

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0; iteration counter=0.
- Reset asserted mid-operation aborts the divide immediately; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a rising edge with start=1, latch |dividend| into the quotient shift register and |divisor| into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits).
  - Record sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB].
  - Set the zero and overflow flags. Overflow means dividend = 100…0 and divisor = all ones.
  - Go to CALC with counter=0 and busy=1. done falls to 0 on this edge.
- CALC, one iteration per edge:
  - Shift {rem, q} left by 1.
  - Compute trial = rem - |divisor| at WIDTH+1 bits.
  - If trial is non-negative: rem=trial and q[0]=1; otherwise q[0]=0.
  - counter increments; after iteration WIDTH-1 go to FIX.
  - Absolute value of the most-negative operand is 2^(WIDTH-1), held as unsigned; no special casing is needed in CALC.
- FIX (one edge):
  - quotient = sign_q ? -q : q, and remainder = sign_r ? -rem : rem, both truncated to WIDTH.
  - done=1 and busy=0; latch the div_by_zero and overflow outputs; return to IDLE.
- Latency: start accepted at edge E0 → done high and results valid in the cycle after edge E0+WIDTH+1 (WIDTH+1 cycles of busy). done lasts exactly one cycle.
- Semantics:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - dividend = quotient*divisor + remainder holds modulo 2^WIDTH.
- Divide by zero:
  - Runs the normal latency.
  - Results: quotient = all ones, remainder = dividend, div_by_zero=1.
  - These results fall naturally from the algorithm plus the sign fix, with sign_q forced to 0 when the divisor is zero.
- Overflow (most-negative / -1): quotient = most-negative value, remainder = 0, overflow=1.
- start while busy=1 is ignored; operands are not re-sampled.
- start held high in the done cycle: the FSM is in IDLE, so a new divide is accepted on that edge, giving back-to-back operation. Outputs hold their old values until the next FIX.
- quotient/remainder/flags hold their last values in IDLE until the next FIX or reset.

Test Plan:
- Positive divide: 100 / 7 → after 33 cycles, done=1 for 1 cycle, quotient=14, remainder=2, both flags 0.
- Signed cases:
  - -100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
  - 100 / -7 → quotient=0xFFFFFFF2, remainder=2.
  - -100 / -7 → quotient=14, remainder=0xFFFFFFFE.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1.
  - 0x80000000 / 2 → quotient=0xC0000000, remainder=0.
  - 7 / 100 → quotient=0, remainder=7.
- Divide by zero: 5 / 0 → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Then -5 / 0 → quotient=0xFFFFFFFF, remainder=0xFFFFFFFB.
- Handshake:
  - Pulse start with 100/7, then pulse start with 9/3 at cycle 10 while busy → result stays 14/2 and only one done pulse occurs.
  - Hold start high with new operands 9/3 in the done cycle → second done exactly 33 cycles later with quotient=3, remainder=0.
- Reset: drop clr_n at cycle 15 of a divide → all outputs 0 immediately, no done. After release, a new 100/7 completes normally.
- Randomized self-check (1000 pairs, including zero divisors): compare against the signed / and % reference model, plus the divide-by-zero and overflow rules above.
